// File: rtl/payload_engine_pkg.sv
// payload_engine_pkg: shared constants, FSM states and the character-class table
package payload_engine_pkg;

   localparam int NUM_CLASSES_DEF = 64;

   typedef enum logic [2:0] {IDLE, SOD, STREAM, FLUSH, EOD} state_t;

   // Raw class table; classes not listed are unused by the current rule set
   function automatic logic [NUM_CLASSES_DEF-1:0] char_class(input logic [7:0] b);
      logic [NUM_CLASSES_DEF-1:0] v;
      v     = '0;
      v[1]  = (b >= 8'h09 && b <= 8'h0D) || b == 8'h20;
      v[8]  = b == 8'h53;
      v[9]  = b == 8'h68;
      v[15] = b == 8'h61;
      v[17] = b == 8'h65;
      return v;
   endfunction

endpackage

// File: rtl/payload_char_decoder_if.sv
// payload_char_decoder_if: byte-wide payload stream with valid/ready handshake
interface payload_char_decoder_if;
   logic [7:0] data;
   logic       valid;
   logic       last;
   logic       ready;
   modport master (output data, valid, last, input ready);
   modport slave  (input data, valid, last, output ready);
endinterface

// File: rtl/payload_class_lut.sv
// payload_class_lut: byte to class vector lookup with optional letter case folding
module payload_class_lut
   import payload_engine_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter bit NOCASE      = 1'b1
) (
   input  logic [7:0]             b,
   output logic [NUM_CLASSES-1:0] vec
);

   logic                       letter;
   logic [NUM_CLASSES_DEF-1:0] raw;

   assign letter = (b >= 8'h41 && b <= 8'h5A) || (b >= 8'h61 && b <= 8'h7A);
   assign raw    = char_class(b) | ((NOCASE && letter) ? char_class(b ^ 8'h20) : '0);
   assign vec    = NUM_CLASSES'(raw);

endmodule

// File: rtl/payload_char_decoder.sv
// payload_char_decoder: turns a payload byte stream into sod/en/class steps for the match engines
module payload_char_decoder
   import payload_engine_pkg::*;
#(
   parameter int NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int FLUSH_BEATS = 2,
   parameter bit NOCASE      = 1'b1,
   parameter int LEN_W       = 16
) (
   input  logic                   clk,
   input  logic                   rst_n,
   payload_char_decoder_if.slave  s,
   output logic                   sod,
   output logic                   en,
   output logic [NUM_CLASSES-1:0] char_vec,
   output logic                   eod,
   output logic [LEN_W-1:0]       pkt_len
);

   state_t                 state;
   logic                   sod_q;
   logic                   last_q;
   logic                   acc;
   logic [7:0]             hold;
   logic [LEN_W-1:0]       cnt;
   logic [3:0]             beat;
   logic [NUM_CLASSES-1:0] cls;

   assign s.ready = rst_n && (state == IDLE || state == STREAM);
   assign acc     = s.valid && s.ready;
   assign sod     = sod_q || !rst_n;

   // The held first byte is classified during SOD; live bytes otherwise
   payload_class_lut #(.NUM_CLASSES(NUM_CLASSES), .NOCASE(NOCASE)) u_lut (
      .b   (state == SOD ? hold : s.data),
      .vec (cls)
   );

   // Packet FSM; every engine-side output is registered and defaults to idle each cycle
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state    <= IDLE;
         sod_q    <= 1'b0;
         last_q   <= 1'b0;
         hold     <= '0;
         cnt      <= '0;
         beat     <= '0;
         en       <= 1'b0;
         eod      <= 1'b0;
         char_vec <= '0;
         pkt_len  <= '0;
      end else begin
         sod_q    <= 1'b0;
         en       <= 1'b0;
         eod      <= 1'b0;
         char_vec <= '0;
         case (state)
            IDLE: if (acc) begin
               hold   <= s.data;
               last_q <= s.last;
               cnt    <= LEN_W'(1);
               sod_q  <= 1'b1;
               state  <= SOD;
            end
            SOD: begin
               en       <= 1'b1;
               char_vec <= cls;
               beat     <= '0;
               state    <= last_q ? FLUSH : STREAM;
            end
            STREAM: if (acc) begin
               en       <= 1'b1;
               char_vec <= cls;
               cnt      <= &cnt ? cnt : cnt + LEN_W'(1);
               beat     <= '0;
               state    <= s.last ? FLUSH : STREAM;
            end
            FLUSH: if (beat == 4'(FLUSH_BEATS)) begin
               eod     <= 1'b1;
               pkt_len <= cnt;
               state   <= EOD;
            end else begin
               en   <= 1'b1;
               beat <= beat + 4'd1;
            end
            EOD: state <= IDLE;
            default: state <= IDLE;
         endcase
      end

endmodule

// File: tb/tb_payload_char_decoder.sv
// tb_payload_char_decoder: cycle-planned directed bench checking two decoder builds against a timeline model
module tb_payload_char_decoder;

   localparam int N  = 512;
   localparam int FB = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        sod_a, en_a, eod_a, sod_b, en_b, eod_b;
   logic [63:0] vec_a, vec_b;
   logic [15:0] len_a;
   logic [3:0]  len_b;

   int checks = 0, errors = 0, cyc = 0, cur = 0, last_c = 0;
   int p_eod1, p_eod2, p_eod5, p_eod6, p_A, dummy, t0;

   bit          e_sod[N], e_en[N], e_eod[N], e_rdy[N], e_lchk[N];
   logic [63:0] e_va[N], e_vb[N];
   int          e_len[N];
   bit          d_rst[N], d_val[N], d_last[N];
   logic [7:0]  d_dat[N];
   logic [7:0]  pb[64];
   int          pg[64];

   always #5 clk = ~clk;

   payload_char_decoder_if ia ();
   payload_char_decoder_if ib ();
   assign ib.data  = ia.data;
   assign ib.valid = ia.valid;
   assign ib.last  = ia.last;

   payload_char_decoder dut_a (
      .clk(clk), .rst_n(rst_n), .s(ia), .sod(sod_a), .en(en_a),
      .char_vec(vec_a), .eod(eod_a), .pkt_len(len_a)
   );

   payload_char_decoder #(.NOCASE(1'b0), .LEN_W(4)) dut_b (
      .clk(clk), .rst_n(rst_n), .s(ib), .sod(sod_b), .en(en_b),
      .char_vec(vec_b), .eod(eod_b), .pkt_len(len_b)
   );

   // Class rules written straight from the class table description
   function automatic logic [63:0] ref_class(input logic [7:0] b, input bit nc);
      logic [63:0] v;
      v     = '0;
      v[1]  = b inside {[8'h09:8'h0D], 8'h20};
      v[8]  = b == 8'h53 || (nc && b == 8'h73);
      v[9]  = b == 8'h68 || (nc && b == 8'h48);
      v[15] = b == 8'h61 || (nc && b == 8'h41);
      v[17] = b == 8'h65 || (nc && b == 8'h45);
      return v;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d got %h expected %h", nm, cyc, act, exp);
      end
   endtask

   task automatic drive(input int c, input logic [7:0] b, input bit l);
      d_val[c]  = 1'b1;
      d_dat[c]  = b;
      d_last[c] = l;
   endtask

   task automatic step(input int c, input logic [7:0] b);
      e_en[c] = 1'b1;
      e_va[c] = ref_class(b, 1'b1);
      e_vb[c] = ref_class(b, 1'b0);
   endtask

   task automatic clear_gaps();
      for (int i = 0; i < 64; i++) pg[i] = 0;
   endtask

   // Lay one packet onto the timeline using the interface latencies:
   // first step at accept+2, later steps at accept+1, FB flush steps, then eod
   task automatic plan_pkt(input int n, input bit early, output int eod_c);
      int s0, t, l;
      s0 = cur;
      t  = cur + 2;
      l  = cur + 2;
      if (early) drive(s0 - 1, pb[0], n == 1);
      drive(s0, pb[0], n == 1);
      e_sod[s0+1] = 1'b1;
      e_rdy[s0+1] = 1'b0;
      step(s0 + 2, pb[0]);
      for (int i = 1; i < n; i++) begin
         t += pg[i];
         if (i == 1 && pg[1] == 0) drive(s0 + 1, pb[1], n == 2);
         drive(t, pb[i], i == n - 1);
         step(t + 1, pb[i]);
         l = t + 1;
         t++;
      end
      for (int c = l; c <= l + FB + 1; c++) e_rdy[c] = 1'b0;
      for (int c = l + 1; c <= l + FB; c++) e_en[c] = 1'b1;
      eod_c         = l + FB + 1;
      e_eod[eod_c]  = 1'b1;
      e_lchk[eod_c] = 1'b1;
      e_len[eod_c]  = n;
      cur           = eod_c + 1;
   endtask

   // Reset discards everything planned from this cycle on
   task automatic plan_reset(input int at, input int len);
      for (int c = at; c < N; c++) begin
         e_sod[c] = 1'b0; e_en[c] = 1'b0; e_eod[c] = 1'b0; e_rdy[c] = 1'b1;
         e_lchk[c] = 1'b0; e_va[c] = '0; e_vb[c] = '0; e_len[c] = 0;
         d_rst[c] = 1'b0; d_val[c] = 1'b0; d_last[c] = 1'b0; d_dat[c] = 8'h61;
      end
      for (int c = at; c < at + len; c++) begin
         d_rst[c] = 1'b1; e_sod[c] = 1'b1; e_rdy[c] = 1'b0; e_lchk[c] = 1'b1;
      end
      cur = at + len;
   endtask

   initial begin
      ia.valid = 1'b0;
      ia.data  = 8'h00;
      ia.last  = 1'b0;
      plan_reset(0, 3);
      clear_gaps();
      pb[0] = 8'h53;
      plan_pkt(1, 1'b0, p_eod1);
      cur += 2;
      pb[0] = 8'h61; pb[1] = 8'h20; pb[2] = 8'h65;
      plan_pkt(3, 1'b0, p_eod2);
      cur += 1;
      pb[0] = 8'h41; pb[1] = 8'h09; pb[2] = 8'h29; pb[3] = 8'h00; pb[4] = 8'h73; pb[5] = 8'h48;
      pb[6] = 8'h45; pb[7] = 8'h0D; pb[8] = 8'h0E; pb[9] = 8'h5A; pb[10] = 8'h65;
      p_A = cur + 2;
      plan_pkt(11, 1'b0, dummy);
      cur += 1;
      pb[0] = 8'h68; pb[1] = 8'h65; pg[1] = 2;
      plan_pkt(2, 1'b0, dummy);
      clear_gaps();
      cur += 1;
      pb[0] = 8'h53; pb[1] = 8'h68; pb[2] = 8'h61; pb[3] = 8'h65; pb[4] = 8'h20;
      t0 = cur;
      plan_pkt(5, 1'b0, dummy);
      plan_reset(t0 + 4, 2);
      pb[0] = 8'h48; pb[1] = 8'h53;
      plan_pkt(2, 1'b0, p_eod5);
      cur += 1;
      for (int i = 0; i < 20; i++) pb[i] = (i % 4 == 0) ? 8'h61 : (i % 4 == 1) ? 8'h68 : (i % 4 == 2) ? 8'h65 : 8'h20;
      plan_pkt(20, 1'b0, p_eod6);
      pb[0] = 8'h65; pb[1] = 8'h53;
      plan_pkt(2, 1'b1, dummy);
      last_c = cur + 3;

      for (int c = 0; c < last_c; c++) begin
         @(posedge clk);
         #1;
         cyc      = c;
         rst_n    = !d_rst[c];
         ia.valid = d_val[c];
         ia.data  = d_dat[c];
         ia.last  = d_last[c];
         @(negedge clk);
         chk("sod_a", 64'(sod_a), 64'(e_sod[c]));
         chk("sod_b", 64'(sod_b), 64'(e_sod[c]));
         chk("en_a", 64'(en_a), 64'(e_en[c]));
         chk("en_b", 64'(en_b), 64'(e_en[c]));
         chk("eod_a", 64'(eod_a), 64'(e_eod[c]));
         chk("eod_b", 64'(eod_b), 64'(e_eod[c]));
         chk("ready_a", 64'(ia.ready), 64'(e_rdy[c]));
         chk("ready_b", 64'(ib.ready), 64'(e_rdy[c]));
         chk("vec_a", vec_a, e_va[c]);
         chk("vec_b", vec_b, e_vb[c]);
         if (e_lchk[c]) begin
            chk("len_a", 64'(len_a), 64'(e_len[c]));
            chk("len_b", 64'(len_b), 64'(e_len[c] > 15 ? 15 : e_len[c]));
         end
         if (c == p_eod1 - 4) chk("pin1_sod", 64'(sod_a), 64'd1);
         if (c == p_eod1 - 3) chk("pin1_bit8", vec_a, 64'h100);
         if (c == p_eod1) begin
            chk("pin1_eod", 64'(eod_a), 64'd1);
            chk("pin1_len", 64'(len_a), 64'd1);
         end
         if (c == p_eod2) chk("pin2_len", 64'(len_a), 64'd3);
         if (c == p_A) begin
            chk("pin3_A_nocase", vec_a, 64'h8000);
            chk("pin3_A_case", vec_b, 64'h0);
         end
         if (c == p_A + 1) begin
            chk("pin3_tab_a", vec_a, 64'h2);
            chk("pin3_tab_b", vec_b, 64'h2);
         end
         if (c == p_A + 2) chk("pin3_paren", vec_a, 64'h0);
         if (c == p_eod5) chk("pin5_len", 64'(len_a), 64'd2);
         if (c == p_eod6) begin
            chk("pin6_len_sat", 64'(len_b), 64'd15);
            chk("pin6_len_full", 64'(len_a), 64'd20);
         end
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
